// File: rtl/riscv151_mmio_pkg.sv
// Shared constants for the Riscv151 MMIO/UART responder: register offsets,
// status bit positions and a helper that packs the status word.
package riscv151_mmio_pkg;

   localparam logic [7:0] ADDR_STATUS   = 8'h00;
   localparam logic [7:0] ADDR_RX_DATA  = 8'h04;
   localparam logic [7:0] ADDR_TX_DATA  = 8'h08;
   localparam logic [7:0] ADDR_CYC_CNT  = 8'h10;
   localparam logic [7:0] ADDR_INST_CNT = 8'h14;
   localparam logic [7:0] ADDR_CNT_RST  = 8'h18;

   localparam int STAT_TX_EMPTY = 0;
   localparam int STAT_RX_VALID = 1;

   // Status register image; every bit not named here reads as zero.
   function automatic logic [31:0] status_word(input logic tx_empty, input logic rx_avail);
      logic [31:0] w;
      w                = 32'h0000_0000;
      w[STAT_TX_EMPTY] = tx_empty;
      w[STAT_RX_VALID] = rx_avail;
      return w;
   endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Circular byte FIFO for the UART receive path. Pointers carry one extra wrap
// bit so full and empty are told apart by pointer comparison alone.
// Used by mmio_uart_ctrl only when RX_FIFO_EN is defined.
module mmio_rx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic [7:0] pop_data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push_s;
   logic        do_pop_s;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push_s  = push_i & ~full_o;
   assign do_pop_s   = pop_i & ~empty_o;

   // Pointer advance; push and pop in one cycle move both pointers.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are only ever read when the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped responder for the Riscv151 I/O region: UART RX/TX staging,
// status, and cycle / retired-instruction counters. Load data is registered
// to match the one-cycle latency of the synchronous memories.
// Build option: define RX_FIFO_EN to replace the single-byte RX holding
// register with an RX_FIFO_DEPTH-entry FIFO.
module mmio_uart_ctrl
   import riscv151_mmio_pkg::*;
#(
   parameter logic [3:0] MMIO_TOP_NIBBLE = 4'h8,
   parameter int         RX_FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_wdata,
   input  logic        mmio_we,
   input  logic        mmio_re,
   output logic [31:0] mmio_rdata,
   input  logic        inst_retire,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   logic        hit_s;
   logic [7:0]  off_s;
   logic        rd_rx_s;
   logic        wr_tx_s;
   logic        wr_cnt_rst_s;
   logic        rx_push_s;
   logic        rx_pop_s;
   logic        rx_full_s;
   logic        rx_empty_s;
   logic [7:0]  rx_head_s;
   logic        tx_accept_s;
   logic        tx_handshake_s;

   logic [31:0] rdata_q, rdata_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] inst_q, inst_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;

   assign hit_s        = (mmio_addr[31:28] == MMIO_TOP_NIBBLE);
   assign off_s        = mmio_addr[7:0];
   assign rd_rx_s      = mmio_re & hit_s & (off_s == ADDR_RX_DATA);
   assign wr_tx_s      = mmio_we & hit_s & (off_s == ADDR_TX_DATA);
   assign wr_cnt_rst_s = mmio_we & hit_s & (off_s == ADDR_CNT_RST);

   // rx_ready depends only on stored state, so a pop never opens a slot in
   // the same cycle and a push can never land on a full buffer.
   assign rx_ready  = ~rx_full_s;
   assign rx_push_s = rx_valid & ~rx_full_s;
   assign rx_pop_s  = rd_rx_s & ~rx_empty_s;

`ifdef RX_FIFO_EN
   mmio_rx_fifo #(
      .DEPTH(RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (rx_push_s),
      .push_data_i (rx_data),
      .pop_i       (rx_pop_s),
      .pop_data_o  (rx_head_s),
      .full_o      (rx_full_s),
      .empty_o     (rx_empty_s)
   );

   logic unused_s;
   assign unused_s = ^{mmio_addr[27:8], mmio_wdata[31:8]};
`else
   logic       rx_full_q;
   logic [7:0] rx_byte_q;

   assign rx_full_s  = rx_full_q;
   assign rx_empty_s = ~rx_full_q;
   assign rx_head_s  = rx_byte_q;

   // Single-byte RX holding register; pop and push are mutually exclusive
   // because a push needs the register empty and a pop needs it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_full_q <= 1'b0;
         rx_byte_q <= 8'h00;
      end else if (rx_pop_s) begin
         rx_full_q <= 1'b0;
      end else if (rx_push_s) begin
         rx_full_q <= 1'b1;
         rx_byte_q <= rx_data;
      end
   end

   logic unused_s;
   assign unused_s = ^{mmio_addr[27:8], mmio_wdata[31:8], (RX_FIFO_DEPTH != 0)};
`endif

   // A TX store is taken when the holding slot is empty or is being drained
   // by the transmitter in this very cycle; otherwise it is dropped.
   assign tx_handshake_s = tx_valid_q & tx_ready;
   assign tx_accept_s    = wr_tx_s & (~tx_valid_q | tx_ready);

   // Load data mux: sampled in the mmio_re cycle, held otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (mmio_re) begin
         if (hit_s) begin
            case (off_s)
               ADDR_STATUS:   rdata_d = status_word(~tx_valid_q, ~rx_empty_s);
               ADDR_RX_DATA:  rdata_d = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_head_s};
               ADDR_CYC_CNT:  rdata_d = cyc_q;
               ADDR_INST_CNT: rdata_d = inst_q;
               default:       rdata_d = 32'h0000_0000;
            endcase
         end else begin
            rdata_d = 32'h0000_0000;
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // TX holding slot next state.
   always_comb begin
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      if (tx_accept_s) begin
         tx_data_d  = mmio_wdata[7:0];
         tx_valid_d = 1'b1;
      end else if (tx_handshake_s) begin
         tx_valid_d = 1'b0;
      end else begin
         tx_valid_d = tx_valid_q;
      end
   end

   // Counters: free-running wrap; a counter-reset store beats any increment.
   always_comb begin
      cyc_d  = cyc_q + 32'd1;
      inst_d = inst_q;
      if (wr_cnt_rst_s) begin
         cyc_d  = 32'h0000_0000;
         inst_d = 32'h0000_0000;
      end else if (inst_retire) begin
         inst_d = inst_q + 32'd1;
      end else begin
         inst_d = inst_q;
      end
   end

   // State registers for read data, TX slot and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q    <= 32'h0000_0000;
         cyc_q      <= 32'h0000_0000;
         inst_q     <= 32'h0000_0000;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         cyc_q      <= cyc_d;
         inst_q     <= inst_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign mmio_rdata = rdata_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboard bench for mmio_uart_ctrl: loads and TX handshakes push their
// expected values into queues; monitors pop and compare when the DUT presents
// load data or a TX handshake. Works with or without RX_FIFO_EN.
module tb_mmio_uart_ctrl;

`ifdef RX_FIFO_EN
   localparam int N_RX = 8;
`else
   localparam int N_RX = 1;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_wdata;
   logic        mmio_we;
   logic        mmio_re;
   logic [31:0] mmio_rdata;
   logic        inst_retire;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        re_pend  = 1'b0;

   logic [31:0] rd_exp_q [$];
   string       rd_name_q [$];
   logic [7:0]  tx_exp_q [$];

   mmio_uart_ctrl #(
      .MMIO_TOP_NIBBLE (4'h8),
      .RX_FIFO_DEPTH   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mmio_addr   (mmio_addr),
      .mmio_wdata  (mmio_wdata),
      .mmio_we     (mmio_we),
      .mmio_re     (mmio_re),
      .mmio_rdata  (mmio_rdata),
      .inst_retire (inst_retire),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Remember which cycles carried a load so the monitor knows when data is due.
   always @(posedge clk) re_pend <= mmio_re;

   // Monitor: compare load data and TX handshakes against the queues.
   always @(negedge clk) begin
      logic [31:0] e;
      logic [7:0]  t;
      string       nm;
      if (re_pend) begin
         n_checks++;
         if (rd_exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL load_unexpected: rdata=%h with no expected value", mmio_rdata);
         end else begin
            e  = rd_exp_q.pop_front();
            nm = rd_name_q.pop_front();
            if (mmio_rdata !== e) begin
               n_errors++;
               $display("FAIL %s: rdata=%h expected=%h", nm, mmio_rdata, e);
            end
         end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         n_checks++;
         if (tx_exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL tx_unexpected: tx_data=%h with no expected byte", tx_data);
         end else begin
            t = tx_exp_q.pop_front();
            if (tx_data !== t) begin
               n_errors++;
               $display("FAIL tx_byte: tx_data=%h expected=%h", tx_data, t);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
      mmio_addr  = a;
      mmio_wdata = d;
      mmio_we    = 1'b1;
      tick();
      mmio_we    = 1'b0;
   endtask

   task automatic mmio_read(input logic [31:0] a, input logic [31:0] exp, input string name);
      mmio_addr = a;
      mmio_re   = 1'b1;
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      tick();
      mmio_re   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mmio_addr = 32'h0; mmio_wdata = 32'h0; mmio_we = 1'b0;
      mmio_re = 1'b0; inst_retire = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      tx_ready = 1'b0;
      repeat (3) tick();
      check("reset_rdata", mmio_rdata, 32'h0);
      check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("reset_tx_data", {24'h0, tx_data}, 32'h0);
      check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
      rst = 1'b0;
      tick();

      // RX single byte
      rx_data = 8'h5A; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      mmio_read(32'h8000_0000, 32'h3, "rx_status_full");
      mmio_read(32'h8000_0004, 32'h5A, "rx_read_5a");
      mmio_read(32'h8000_0000, 32'h1, "rx_status_empty");
      mmio_read(32'h8000_0004, 32'h0, "rx_read_empty");

      // TX stall with dropped second store
      mmio_write(32'h8000_0008, 32'hFFFF_FF41);
      check("tx_valid_c1", {31'h0, tx_valid}, 32'h1);
      check("tx_data_c1", {24'h0, tx_data}, 32'h41);
      mmio_read(32'h8000_0000, 32'h0, "tx_status_full");
      check("tx_data_c2", {24'h0, tx_data}, 32'h41);
      mmio_write(32'h8000_0008, 32'h42);
      check("tx_data_c3_drop", {24'h0, tx_data}, 32'h41);
      check("tx_valid_c3", {31'h0, tx_valid}, 32'h1);
      tx_ready = 1'b1;
      tx_exp_q.push_back(8'h41);
      tick();
      tx_ready = 1'b0;
      check("tx_valid_after_hs", {31'h0, tx_valid}, 32'h0);

      // Handshake and new store in the same cycle
      mmio_write(32'h8000_0008, 32'h43);
      tx_ready = 1'b1;
      tx_exp_q.push_back(8'h43);
      mmio_write(32'h8000_0008, 32'h44);
      check("tx_reload_valid", {31'h0, tx_valid}, 32'h1);
      check("tx_reload_data", {24'h0, tx_data}, 32'h44);
      tx_exp_q.push_back(8'h44);
      tick();
      tx_ready = 1'b0;
      check("tx_reload_drained", {31'h0, tx_valid}, 32'h0);

      // Same-cycle store and load, unmapped and non-hit accesses
      mmio_addr = 32'h8000_0008; mmio_wdata = 32'h55; mmio_we = 1'b1; mmio_re = 1'b1;
      rd_exp_q.push_back(32'h0); rd_name_q.push_back("wo_tx_read");
      tick();
      mmio_we = 1'b0; mmio_re = 1'b0;
      check("same_cycle_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("same_cycle_tx_data", {24'h0, tx_data}, 32'h55);
      mmio_read(32'h8000_0000, 32'h0, "status_tx_busy");
      tx_ready = 1'b1;
      tx_exp_q.push_back(8'h55);
      tick();
      tx_ready = 1'b0;
      mmio_read(32'h8000_0020, 32'h0, "unmapped_0x20");
      mmio_read(32'h0000_0000, 32'h0, "nonhit_status");
      mmio_read(32'h9000_0010, 32'h0, "nonhit_nibble9");
      mmio_read(32'h8000_0018, 32'h0, "wo_cnt_rst_read");
      mmio_write(32'h0000_0008, 32'h66);
      check("nonhit_tx_ignored", {31'h0, tx_valid}, 32'h0);
      mmio_addr = 32'h8000_0000; mmio_wdata = 32'h0; mmio_we = 1'b1; mmio_re = 1'b1;
      rd_exp_q.push_back(32'h1); rd_name_q.push_back("ro_status_wr_rd");
      tick();
      mmio_we = 1'b0; mmio_re = 1'b0;
      tick(); tick();
      check("rdata_hold", mmio_rdata, 32'h1);

      // Counters: reset, 100 cycles with 37 retires, reset overriding retire
      mmio_write(32'h8000_0018, 32'h0);
      for (int i = 0; i < 100; i++) begin
         inst_retire = (i < 37);
         tick();
      end
      inst_retire = 1'b0;
      mmio_read(32'h8000_0014, 32'd37, "inst_count_37");
      mmio_read(32'h8000_0010, 32'd101, "cyc_count_101");
      inst_retire = 1'b1;
      mmio_write(32'h8000_0018, 32'hDEAD_BEEF);
      inst_retire = 1'b0;
      mmio_read(32'h8000_0010, 32'd0, "cyc_after_rst");
      mmio_read(32'h8000_0014, 32'd0, "inst_after_rst");
      mmio_read(32'h8000_0010, 32'd2, "cyc_counting");
      force dut.cyc_q = 32'hFFFF_FFFE;
      #1;
      release dut.cyc_q;
      mmio_read(32'h8000_0010, 32'hFFFF_FFFE, "cyc_pre_wrap");
      mmio_read(32'h8000_0010, 32'hFFFF_FFFF, "cyc_max");
      mmio_read(32'h8000_0010, 32'h0, "cyc_wrapped");

      // RX buffer fill, back-pressure and ordered drain
      for (int i = 1; i <= N_RX; i++) begin
         rx_data = 8'(i); rx_valid = 1'b1;
         check("rx_ready_before_push", {31'h0, rx_ready}, 32'h1);
         tick();
      end
      rx_data = 8'(N_RX + 1);
      check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
      tick();
      check("rx_ready_full_hold", {31'h0, rx_ready}, 32'h0);
      mmio_read(32'h8000_0000, 32'h3, "rx_status_full_buf");
      mmio_read(32'h8000_0004, 32'h1, "rx_pop_first");
      check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
      tick();
      rx_valid = 1'b0;
      check("rx_ready_refilled", {31'h0, rx_ready}, 32'h0);
      for (int i = 2; i <= N_RX + 1; i++) begin
         mmio_read(32'h8000_0004, 32'(i), "rx_pop_order");
      end
      mmio_read(32'h8000_0004, 32'h0, "rx_pop_drained");

      // Reset in the middle of activity
      mmio_write(32'h8000_0008, 32'h77);
      rx_data = 8'hAB; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      inst_retire = 1'b1;
      tick();
      inst_retire = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("midrst_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("midrst_rdata", mmio_rdata, 32'h0);
      mmio_read(32'h8000_0010, 32'h0, "midrst_cyc");
      mmio_read(32'h8000_0014, 32'h0, "midrst_inst");
      mmio_read(32'h8000_0000, 32'h1, "midrst_status");
      mmio_read(32'h8000_0004, 32'h0, "midrst_rx_flushed");

      tick(); tick();
      n_checks++;
      if (rd_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: loads_left=%0d tx_left=%0d expected=0",
                  rd_exp_q.size(), tx_exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
